// File: rtl/pipe_hazard_scoreboard_if.sv
// ID-side bundle for the hazard scoreboard: decoded operands and stage result buses in, forward/stall decisions out.
// master drives the ID/pipeline side; slave is the scoreboard itself.
interface pipe_hazard_scoreboard_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int NSRC   = 2,
  parameter int LAT_W  = 2
);
  logic                     id_valid;
  logic [NSRC*REG_AW-1:0]   id_rs;
  logic [NSRC-1:0]          id_rs_use;
  logic [REG_AW-1:0]        id_rd;
  logic                     id_we;
  logic [LAT_W-1:0]         id_lat;
  logic                     flush;
  logic [DEPTH*XLEN-1:0]    st_data;
  logic [NSRC-1:0]          fwd_en;
  logic [NSRC*XLEN-1:0]     fwd_data;
  logic                     stall;
  logic                     issue;
  logic [31:0]              stall_cnt;

  modport master (
    output id_valid, id_rs, id_rs_use, id_rd, id_we, id_lat, flush, st_data,
    input  fwd_en, fwd_data, stall, issue, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_use, id_rd, id_we, id_lat, flush, st_data,
    output fwd_en, fwd_data, stall, issue, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// Tracks in-flight writers over DEPTH stages and picks a forward source per operand; decisions are combinational from state.
// Downstream stages always advance; a not-yet-ready youngest writer stalls ID, which holds until the result is forwardable.
module pipe_hazard_scoreboard #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int NSRC   = 2,
  parameter int LAT_W  = 2
) (
  input logic                      clk,
  input logic                      rst,
  pipe_hazard_scoreboard_if.slave  bus
);

  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(DEPTH - 1);

  logic [DEPTH-1:0]  v_q, v_d;
  logic [REG_AW-1:0] rd_q  [DEPTH];
  logic [REG_AW-1:0] rd_d  [DEPTH];
  logic [LAT_W-1:0]  cnt_q [DEPTH];
  logic [LAT_W-1:0]  cnt_d [DEPTH];
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic [NSRC-1:0]      hazard;
  logic [NSRC-1:0]      fwd_en;
  logic [NSRC*XLEN-1:0] fwd_data;
  logic                 stall;
  logic                 issue;
  logic [LAT_W-1:0]     lat_eff;

  // Per-operand match: scanning oldest to youngest lets the youngest writer win,
  // so an older ready copy can never mask a younger pending one.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [REG_AW-1:0] rs;
    logic              chk;
    logic              hit;
    logic              rdy;
    logic [XLEN-1:0]   dat;

    assign rs  = bus.id_rs[i*REG_AW +: REG_AW];
    assign chk = bus.id_rs_use[i] && (rs != '0);

    always_comb begin
      hit = 1'b0;
      rdy = 1'b0;
      dat = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (v_q[k] && (rd_q[k] == rs)) begin
          hit = 1'b1;
          rdy = (cnt_q[k] == '0);
          dat = bus.st_data[k*XLEN +: XLEN];
        end
      end
    end

    assign fwd_en[i]                 = chk & hit & rdy;
    assign hazard[i]                 = chk & hit & ~rdy;
    assign fwd_data[i*XLEN +: XLEN]  = (chk & hit & rdy) ? dat : '0;
  end

  assign stall   = bus.id_valid & ~bus.flush & (|hazard);
  assign issue   = bus.id_valid & ~bus.flush & ~stall;
  assign lat_eff = (bus.id_lat > LAT_MAX) ? LAT_MAX : bus.id_lat;

  always_comb begin
    v_d         = '0;
    v_d[0]      = issue & bus.id_we & (bus.id_rd != '0);
    rd_d[0]     = issue ? bus.id_rd : '0;
    cnt_d[0]    = issue ? lat_eff : '0;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k]   = v_q[k-1];
      rd_d[k]  = rd_q[k-1];
      cnt_d[k] = (cnt_q[k-1] == '0) ? '0 : cnt_q[k-1] - LAT_W'(1);
    end
    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      v_q         <= v_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.fwd_en    = fwd_en;
  assign bus.fwd_data  = fwd_data;
  assign bus.stall     = stall;
  assign bus.issue     = issue;
  assign bus.stall_cnt = stall_cnt_q;

  // Oversized latencies are clamped in hardware but flag a decoder bug.
  a_lat_range: assert property (@(posedge clk) disable iff (rst) !(issue && (bus.id_lat > LAT_MAX)))
    else $error("pipe_hazard_scoreboard: id_lat %0d exceeds DEPTH-1", bus.id_lat);

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench: one shared stimulus stream drives a DEPTH=3/NSRC=2 and a DEPTH=4/NSRC=3 scoreboard side by side.
module tb_pipe_hazard_scoreboard;

  logic clk;
  logic rst;

  logic        valid, flush, we;
  logic [4:0]  rd;
  logic [1:0]  lat;
  logic [4:0]  rs [3];
  logic [2:0]  use_v;
  logic [31:0] st [4];

  int checks;
  int failures;
  int exp_cnt;

  pipe_hazard_scoreboard_if #(.XLEN(32), .REG_AW(5), .DEPTH(3), .NSRC(2), .LAT_W(2)) bus_a ();
  pipe_hazard_scoreboard_if #(.XLEN(32), .REG_AW(5), .DEPTH(4), .NSRC(3), .LAT_W(2)) bus_b ();

  pipe_hazard_scoreboard #(.XLEN(32), .REG_AW(5), .DEPTH(3), .NSRC(2), .LAT_W(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  pipe_hazard_scoreboard #(.XLEN(32), .REG_AW(5), .DEPTH(4), .NSRC(3), .LAT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  assign bus_a.id_valid  = valid;
  assign bus_a.flush     = flush;
  assign bus_a.id_we     = we;
  assign bus_a.id_rd     = rd;
  assign bus_a.id_lat    = lat;
  assign bus_a.id_rs     = {rs[1], rs[0]};
  assign bus_a.id_rs_use = use_v[1:0];
  assign bus_a.st_data   = {st[2], st[1], st[0]};

  assign bus_b.id_valid  = valid;
  assign bus_b.flush     = flush;
  assign bus_b.id_we     = we;
  assign bus_b.id_rd     = rd;
  assign bus_b.id_lat    = lat;
  assign bus_b.id_rs     = {rs[2], rs[1], rs[0]};
  assign bus_b.id_rs_use = use_v;
  assign bus_b.st_data   = {st[3], st[2], st[1], st[0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr_in();
    valid = 1'b0; flush = 1'b0; we = 1'b0; rd = '0; lat = '0; use_v = '0;
    for (int i = 0; i < 3; i++) rs[i] = '0;
    for (int i = 0; i < 4; i++) st[i] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clr_in();
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_in();
    valid = 1'b1;
    #3;
    checks++; if (bus_a.stall !== 1'b0) begin failures++; $display("FAIL rst_stall_a got=%0h exp=0", bus_a.stall); end
    checks++; if (bus_a.issue !== 1'b1) begin failures++; $display("FAIL rst_issue_a got=%0h exp=1", bus_a.issue); end
    checks++; if (bus_a.fwd_en !== 2'b00 || bus_a.fwd_data !== 64'h0) begin failures++; $display("FAIL rst_fwd_a en=%0h data=%0h exp=0", bus_a.fwd_en, bus_a.fwd_data); end
    checks++; if (bus_a.stall_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt_a got=%0d exp=0", bus_a.stall_cnt); end
    checks++; if (bus_b.stall !== 1'b0 || bus_b.issue !== 1'b1 || bus_b.fwd_en !== 3'b000 || bus_b.stall_cnt !== 32'd0) begin failures++; $display("FAIL rst_b stall=%0h issue=%0h en=%0h cnt=%0d exp=0/1/0/0", bus_b.stall, bus_b.issue, bus_b.fwd_en, bus_b.stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_alu_chain();
    clr_in(); valid = 1'b1; we = 1'b1; rd = 5'd5; lat = 2'd0;
    #2;
    checks++; if (bus_a.issue !== 1'b1 || bus_b.issue !== 1'b1) begin failures++; $display("FAIL alu_issue a=%0h b=%0h exp=1", bus_a.issue, bus_b.issue); end
    step();
    clr_in(); valid = 1'b1; rs[0] = 5'd5; rs[1] = 5'd3; rs[2] = 5'd5; use_v = 3'b111; st[0] = 32'h1234;
    #2;
    checks++; if (bus_a.fwd_en !== 2'b01) begin failures++; $display("FAIL alu_en_a got=%0b exp=01", bus_a.fwd_en); end
    checks++; if (bus_a.fwd_data !== {32'h0, 32'h1234}) begin failures++; $display("FAIL alu_data_a got=%0h exp=1234", bus_a.fwd_data); end
    checks++; if (bus_a.stall !== 1'b0 || bus_a.issue !== 1'b1) begin failures++; $display("FAIL alu_stall_a stall=%0h issue=%0h exp=0/1", bus_a.stall, bus_a.issue); end
    checks++; if (bus_b.fwd_en !== 3'b101) begin failures++; $display("FAIL alu_en_b got=%0b exp=101", bus_b.fwd_en); end
    checks++; if (bus_b.fwd_data !== {32'h1234, 32'h0, 32'h1234} || bus_b.stall !== 1'b0) begin failures++; $display("FAIL alu_data_b got=%0h stall=%0h exp=1234_0_1234/0", bus_b.fwd_data, bus_b.stall); end
    step();
    idle(5);
  endtask

  task automatic test_load_use();
    clr_in(); valid = 1'b1; we = 1'b1; rd = 5'd6; lat = 2'd1;
    step();
    clr_in(); valid = 1'b1; rs[0] = 5'd6; use_v = 3'b001;
    #2;
    checks++; if (bus_a.stall !== 1'b1 || bus_a.issue !== 1'b0 || bus_a.fwd_en !== 2'b00) begin failures++; $display("FAIL lu_stall_a stall=%0h issue=%0h en=%0b exp=1/0/00", bus_a.stall, bus_a.issue, bus_a.fwd_en); end
    checks++; if (bus_b.stall !== 1'b1 || bus_b.issue !== 1'b0) begin failures++; $display("FAIL lu_stall_b stall=%0h issue=%0h exp=1/0", bus_b.stall, bus_b.issue); end
    step();
    exp_cnt++;
    st[1] = 32'hBEEF;
    #2;
    checks++; if (bus_a.stall !== 1'b0 || bus_a.issue !== 1'b1) begin failures++; $display("FAIL lu_release_a stall=%0h issue=%0h exp=0/1", bus_a.stall, bus_a.issue); end
    checks++; if (bus_a.fwd_en !== 2'b01 || bus_a.fwd_data[31:0] !== 32'hBEEF) begin failures++; $display("FAIL lu_fwd_a en=%0b data=%0h exp=01/beef", bus_a.fwd_en, bus_a.fwd_data[31:0]); end
    checks++; if (bus_a.stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL lu_cnt_a got=%0d exp=%0d", bus_a.stall_cnt, exp_cnt); end
    checks++; if (bus_b.fwd_en !== 3'b001 || bus_b.fwd_data[31:0] !== 32'hBEEF || bus_b.stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL lu_b en=%0b data=%0h cnt=%0d exp=001/beef/%0d", bus_b.fwd_en, bus_b.fwd_data[31:0], bus_b.stall_cnt, exp_cnt); end
    step();
    idle(5);
  endtask

  task automatic test_youngest_wins();
    clr_in(); valid = 1'b1; we = 1'b1; rd = 5'd7; lat = 2'd0;
    step();
    clr_in(); valid = 1'b1;
    step();
    clr_in(); valid = 1'b1; we = 1'b1; rd = 5'd7; lat = 2'd1;
    step();
    clr_in(); valid = 1'b1; rs[0] = 5'd7; use_v = 3'b001; st[0] = 32'h5555; st[2] = 32'hAAAA;
    #2;
    checks++; if (bus_a.stall !== 1'b1 || bus_a.fwd_en !== 2'b00 || bus_a.fwd_data !== 64'h0) begin failures++; $display("FAIL yw_stall_a stall=%0h en=%0b data=%0h exp=1/00/0", bus_a.stall, bus_a.fwd_en, bus_a.fwd_data); end
    checks++; if (bus_b.stall !== 1'b1 || bus_b.fwd_en !== 3'b000) begin failures++; $display("FAIL yw_stall_b stall=%0h en=%0b exp=1/000", bus_b.stall, bus_b.fwd_en); end
    step();
    exp_cnt++;
    st[1] = 32'h7777;
    #2;
    checks++; if (bus_a.stall !== 1'b0 || bus_a.fwd_en !== 2'b01 || bus_a.fwd_data[31:0] !== 32'h7777) begin failures++; $display("FAIL yw_fwd_a stall=%0h en=%0b data=%0h exp=0/01/7777", bus_a.stall, bus_a.fwd_en, bus_a.fwd_data[31:0]); end
    checks++; if (bus_b.stall !== 1'b0 || bus_b.fwd_en !== 3'b001 || bus_b.fwd_data[31:0] !== 32'h7777) begin failures++; $display("FAIL yw_fwd_b stall=%0h en=%0b data=%0h exp=0/001/7777", bus_b.stall, bus_b.fwd_en, bus_b.fwd_data[31:0]); end
    checks++; if (bus_a.stall_cnt !== 32'(exp_cnt) || bus_b.stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL yw_cnt a=%0d b=%0d exp=%0d", bus_a.stall_cnt, bus_b.stall_cnt, exp_cnt); end
    step();
    idle(5);
  endtask

  task automatic test_flush_vs_stall();
    clr_in(); valid = 1'b1; we = 1'b1; rd = 5'd8; lat = 2'd1;
    step();
    // The flushed instruction would itself write x9 with a load latency.
    clr_in(); valid = 1'b1; flush = 1'b1; rs[0] = 5'd8; use_v = 3'b001; we = 1'b1; rd = 5'd9; lat = 2'd1;
    #2;
    checks++; if (bus_a.stall !== 1'b0 || bus_a.issue !== 1'b0) begin failures++; $display("FAIL fl_a stall=%0h issue=%0h exp=0/0", bus_a.stall, bus_a.issue); end
    checks++; if (bus_b.stall !== 1'b0 || bus_b.issue !== 1'b0) begin failures++; $display("FAIL fl_b stall=%0h issue=%0h exp=0/0", bus_b.stall, bus_b.issue); end
    step();
    clr_in(); valid = 1'b1; rs[0] = 5'd9; rs[1] = 5'd8; use_v = 3'b011; st[1] = 32'h8888;
    #2;
    checks++; if (bus_a.stall_cnt !== 32'(exp_cnt) || bus_b.stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL fl_cnt a=%0d b=%0d exp=%0d", bus_a.stall_cnt, bus_b.stall_cnt, exp_cnt); end
    checks++; if (bus_a.stall !== 1'b0 || bus_a.fwd_en !== 2'b10 || bus_a.fwd_data !== {32'h8888, 32'h0}) begin failures++; $display("FAIL fl_bubble_a stall=%0h en=%0b data=%0h exp=0/10/8888_0", bus_a.stall, bus_a.fwd_en, bus_a.fwd_data); end
    checks++; if (bus_b.stall !== 1'b0 || bus_b.fwd_en !== 3'b010) begin failures++; $display("FAIL fl_bubble_b stall=%0h en=%0b exp=0/010", bus_b.stall, bus_b.fwd_en); end
    step();
    idle(5);
  endtask

  task automatic test_x0_unused();
    clr_in(); valid = 1'b1; we = 1'b1; rd = 5'd0; lat = 2'd1;
    step();
    clr_in(); valid = 1'b1; rs[0] = 5'd0; use_v = 3'b001; we = 1'b1; rd = 5'd10; lat = 2'd1;
    #2;
    checks++; if (bus_a.stall !== 1'b0 || bus_a.fwd_en !== 2'b00 || bus_a.issue !== 1'b1) begin failures++; $display("FAIL x0_a stall=%0h en=%0b issue=%0h exp=0/00/1", bus_a.stall, bus_a.fwd_en, bus_a.issue); end
    checks++; if (bus_b.stall !== 1'b0 || bus_b.fwd_en !== 3'b000) begin failures++; $display("FAIL x0_b stall=%0h en=%0b exp=0/000", bus_b.stall, bus_b.fwd_en); end
    step();
    clr_in(); valid = 1'b1; rs[0] = 5'd10; rs[1] = 5'd0; use_v = 3'b010;
    #2;
    checks++; if (bus_a.stall !== 1'b0 || bus_a.fwd_en !== 2'b00 || bus_a.issue !== 1'b1) begin failures++; $display("FAIL unused_a stall=%0h en=%0b issue=%0h exp=0/00/1", bus_a.stall, bus_a.fwd_en, bus_a.issue); end
    checks++; if (bus_b.stall !== 1'b0 || bus_b.issue !== 1'b1) begin failures++; $display("FAIL unused_b stall=%0h issue=%0h exp=0/1", bus_b.stall, bus_b.issue); end
    valid = 1'b0; use_v = 3'b001;
    #1;
    checks++; if (bus_a.stall !== 1'b0 || bus_a.issue !== 1'b0 || bus_b.stall !== 1'b0 || bus_b.issue !== 1'b0) begin failures++; $display("FAIL novalid a=%0h/%0h b=%0h/%0h exp=0/0", bus_a.stall, bus_a.issue, bus_b.stall, bus_b.issue); end
    step();
    idle(5);
  endtask

  task automatic test_reset_midflight();
    clr_in(); valid = 1'b1; we = 1'b1; rd = 5'd11; lat = 2'd2;
    step();
    rd = 5'd12;
    step();
    rd = 5'd13;
    step();
    clr_in(); valid = 1'b1; rs[0] = 5'd13; rs[1] = 5'd11; use_v = 3'b011; st[2] = 32'h1111;
    #2;
    checks++; if (bus_a.stall !== 1'b1 || bus_a.fwd_en !== 2'b10 || bus_a.stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL mid_pre_a stall=%0h en=%0b cnt=%0d exp=1/10/%0d", bus_a.stall, bus_a.fwd_en, bus_a.stall_cnt, exp_cnt); end
    checks++; if (bus_b.stall !== 1'b1 || bus_b.fwd_en !== 3'b010) begin failures++; $display("FAIL mid_pre_b stall=%0h en=%0b exp=1/010", bus_b.stall, bus_b.fwd_en); end
    rst = 1'b1;
    #1;
    checks++; if (bus_a.stall !== 1'b0 || bus_a.fwd_en !== 2'b00 || bus_a.stall_cnt !== 32'd0 || bus_a.issue !== 1'b1) begin failures++; $display("FAIL mid_rst_a stall=%0h en=%0b cnt=%0d issue=%0h exp=0/00/0/1", bus_a.stall, bus_a.fwd_en, bus_a.stall_cnt, bus_a.issue); end
    checks++; if (bus_b.stall !== 1'b0 || bus_b.fwd_en !== 3'b000 || bus_b.stall_cnt !== 32'd0) begin failures++; $display("FAIL mid_rst_b stall=%0h en=%0b cnt=%0d exp=0/000/0", bus_b.stall, bus_b.fwd_en, bus_b.stall_cnt); end
    #1;
    rst = 1'b0;
    clr_in();
    step();
    idle(2);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest_wins();
    test_flush_vs_stall();
    test_x0_unused();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
